// File: rtl/acc_alu_unit.sv
// Accumulator ALU: combines a captured operand with an internal accumulator under
// a valid/ready handshake; result and flags are registered and held until consumed.
module acc_alu_unit #(
    parameter int WIDTH  = 4,
    parameter bit SAT_EN = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [2:0]       op,
    input  logic             acc_we,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [3:0]       flags,
    output logic [WIDTH-1:0] accu
);

    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_DONE} state_t;

    localparam logic [2:0] OP_PASS_A = 3'd0;
    localparam logic [2:0] OP_SUB    = 3'd1;
    localparam logic [2:0] OP_PASS_B = 3'd2;
    localparam logic [2:0] OP_ADD    = 3'd3;
    localparam logic [2:0] OP_NAND   = 3'd4;
    localparam logic [2:0] OP_XOR    = 3'd5;
    localparam logic [2:0] OP_SHL    = 3'd6;
    localparam logic [2:0] OP_ZERO   = 3'd7;

    state_t             state;
    state_t             state_nxt;

    logic [WIDTH-1:0]   a_p0;
    logic [2:0]         op_p0;
    logic               we_p0;

    logic [WIDTH-1:0]   res_p1;
    logic [3:0]         flags_p1;
    logic [WIDTH-1:0]   accu_q;

    logic [WIDTH:0]     sum_w;
    logic [WIDTH:0]     dif_w;
    logic [WIDTH-1:0]   alu_res;
    logic               alu_c;
    logic               alu_v;

    // Saturation only ever touches the result; carry/ovf still report the raw outcome.
    function automatic logic [WIDTH-1:0] sat_add(input logic [WIDTH:0] s);
        if (SAT_EN && s[WIDTH])
            return '1;
        return s[WIDTH-1:0];
    endfunction

    function automatic logic [WIDTH-1:0] sat_sub(input logic [WIDTH:0] d);
        if (SAT_EN && d[WIDTH])
            return '0;
        return d[WIDTH-1:0];
    endfunction

    always_ff @(posedge clk) begin
        if (!reset)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (in_valid)  state_nxt = S_EXEC;
            S_EXEC:                 state_nxt = S_DONE;
            S_DONE:  if (out_ready) state_nxt = S_IDLE;
            default:                state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == S_IDLE);
        out_valid = (state == S_DONE);
        out_data  = out_valid ? res_p1 : '0;
        flags     = flags_p1;
        accu      = accu_q;
    end

    // Stage p0: command capture at the accepting edge
    always_ff @(posedge clk) begin
        if (state == S_IDLE && in_valid) begin
            a_p0  <= in_data;
            op_p0 <= op;
            we_p0 <= acc_we;
        end
    end

    always_comb begin
        sum_w   = {1'b0, a_p0} + {1'b0, accu_q};
        dif_w   = {1'b0, a_p0} - {1'b0, accu_q};
        alu_res = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        case (op_p0)
            OP_PASS_A: alu_res = a_p0;
            OP_SUB: begin
                alu_res = sat_sub(dif_w);
                alu_c   = dif_w[WIDTH];
                alu_v   = (a_p0[WIDTH-1] != accu_q[WIDTH-1]) &&
                          (dif_w[WIDTH-1] != a_p0[WIDTH-1]);
            end
            OP_PASS_B: alu_res = accu_q;
            OP_ADD: begin
                alu_res = sat_add(sum_w);
                alu_c   = sum_w[WIDTH];
                alu_v   = (a_p0[WIDTH-1] == accu_q[WIDTH-1]) &&
                          (sum_w[WIDTH-1] != a_p0[WIDTH-1]);
            end
            OP_NAND:   alu_res = ~(a_p0 & accu_q);
            OP_XOR:    alu_res = a_p0 ^ accu_q;
            OP_SHL: begin
                alu_res = {a_p0[WIDTH-2:0], 1'b0};
                alu_c   = a_p0[WIDTH-1];
            end
            OP_ZERO:   alu_res = '0;
            default:   alu_res = '0;
        endcase
    end

    // Stage p1: result, flags and accumulator write-back during EXEC
    always_ff @(posedge clk) begin
        if (!reset) begin
            res_p1   <= '0;
            flags_p1 <= '0;
            accu_q   <= '0;
        end else if (state == S_EXEC) begin
            res_p1   <= alu_res;
            flags_p1 <= {alu_res[WIDTH-1], alu_v, alu_c, (alu_res == '0)};
            if (we_p0)
                accu_q <= alu_res;
        end
    end

endmodule

// File: tb/tb_acc_alu_unit.sv
// Scoreboard bench: plain-integer reference model for a wrapping and a saturating
// instance driven by the same handshake stimulus.
module tb_acc_alu_unit;

    localparam int W = 4;
    localparam int M = 1 << W;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         reset;
    logic         in_valid;
    logic [W-1:0] in_data;
    logic [2:0]   op;
    logic         acc_we;
    logic         out_ready;

    logic         in_ready0, out_valid0, in_ready1, out_valid1;
    logic [W-1:0] out_data0, accu0, out_data1, accu1;
    logic [3:0]   flags0, flags1;

    acc_alu_unit #(.WIDTH(W), .SAT_EN(1'b0)) dut0 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready0),
        .in_data(in_data), .op(op), .acc_we(acc_we), .out_valid(out_valid0),
        .out_ready(out_ready), .out_data(out_data0), .flags(flags0), .accu(accu0)
    );

    acc_alu_unit #(.WIDTH(W), .SAT_EN(1'b1)) dut1 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready1),
        .in_data(in_data), .op(op), .acc_we(acc_we), .out_valid(out_valid1),
        .out_ready(out_ready), .out_data(out_data1), .flags(flags1), .accu(accu1)
    );

    typedef struct {
        int res0; int fl0; int acc0;
        int res1; int fl1; int acc1;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   macc0    = 0;
    int   macc1    = 0;
    int   last_out0, last_fl0, last_acc0, last_out1, last_fl1, last_acc1;

    task automatic chk(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic int sx(input int v);
        return (v >= M / 2) ? v - M : v;
    endfunction

    // Reference: flags packed as neg*8 + ovf*4 + carry*2 + zero
    task automatic model(input int a, input int b, input int o, input bit sat,
                         output int res, output int fl);
        int r, c, v, s;
        r = 0; c = 0; v = 0;
        case (o)
            0: r = a;
            1: begin
                r = a - b;
                c = (a < b) ? 1 : 0;
                s = sx(a) - sx(b);
                v = (s < -M / 2 || s > M / 2 - 1) ? 1 : 0;
                if (sat && c == 1) r = 0;
            end
            2: r = b;
            3: begin
                r = a + b;
                c = (r >= M) ? 1 : 0;
                s = sx(a) + sx(b);
                v = (s < -M / 2 || s > M / 2 - 1) ? 1 : 0;
                if (sat && c == 1) r = M - 1;
            end
            4: r = (M - 1) - (a & b);
            5: r = a ^ b;
            6: begin
                r = a * 2;
                c = (a >= M / 2) ? 1 : 0;
            end
            default: r = 0;
        endcase
        r   = ((r % M) + M) % M;
        res = r;
        fl  = ((r >= M / 2) ? 8 : 0) + v * 4 + c * 2 + ((r == 0) ? 1 : 0);
    endtask

    // Monitor: checks whatever the DUTs present against the scoreboard head
    always @(negedge clk) begin
        if (reset) begin
            if (out_valid0 || out_valid1) begin
                if (sb_q.size() == 0) begin
                    chk("unexpected_output", 1, 0);
                end else begin
                    mon_e = sb_q[0];
                    chk("mon_valid0", int'(out_valid0), 1);
                    chk("mon_valid1", int'(out_valid1), 1);
                    chk("mon_data0", int'(out_data0), mon_e.res0);
                    chk("mon_flags0", int'(flags0), mon_e.fl0);
                    chk("mon_accu0", int'(accu0), mon_e.acc0);
                    chk("mon_data1", int'(out_data1), mon_e.res1);
                    chk("mon_flags1", int'(flags1), mon_e.fl1);
                    chk("mon_accu1", int'(accu1), mon_e.acc1);
                    if (out_ready)
                        void'(sb_q.pop_front());
                end
            end else begin
                chk("idle_data0", int'(out_data0), 0);
                chk("idle_data1", int'(out_data1), 0);
            end
        end
    end

    task automatic do_op(input int a, input int o, input bit we, input int hold,
                         input bit pulse, input bit rst_mid);
        int   cyc;
        int   r, f;
        exp_t e;
        cyc = 0;
        while (!(in_ready0 && in_ready1) && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
        end
        if (cyc >= 20) begin
            chk("in_ready_timeout", 0, 1);
            return;
        end
        in_valid = 1'b1;
        in_data  = W'(a);
        op       = 3'(o);
        acc_we   = we;
        @(posedge clk);
        model(a, macc0, o, 1'b0, r, f);
        e.res0 = r; e.fl0 = f;
        if (we) macc0 = r;
        e.acc0 = macc0;
        model(a, macc1, o, 1'b1, r, f);
        e.res1 = r; e.fl1 = f;
        if (we) macc1 = r;
        e.acc1 = macc1;
        #1;
        in_valid = 1'b0;
        in_data  = W'($urandom);
        op       = 3'($urandom);
        acc_we   = 1'($urandom);
        if (rst_mid) begin
            reset = 1'b0;
            @(posedge clk); #1;
            reset = 1'b1;
            macc0 = 0;
            macc1 = 0;
            return;
        end
        sb_q.push_back(e);
        @(posedge clk); #1;
        chk("latency_valid0", int'(out_valid0), 1);
        chk("latency_valid1", int'(out_valid1), 1);
        chk("busy_in_ready0", int'(in_ready0), 0);
        last_out0 = int'(out_data0); last_fl0 = int'(flags0); last_acc0 = int'(accu0);
        last_out1 = int'(out_data1); last_fl1 = int'(flags1); last_acc1 = int'(accu1);
        for (int i = 0; i < hold; i++) begin
            if (pulse && i == 0) begin
                in_valid = 1'b1;
                in_data  = W'(9);
                op       = 3'd0;
                acc_we   = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            @(posedge clk); #1;
            chk("hold_in_ready0", int'(in_ready0), 0);
            chk("hold_accu0", int'(accu0), e.acc0);
            chk("hold_accu1", int'(accu1), e.acc1);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("in_ready_after0", int'(in_ready0), 1);
        chk("in_ready_after1", int'(in_ready1), 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset     = 1'b0;
        in_valid  = 1'b1;
        in_data   = W'(5);
        op        = 3'd3;
        acc_we    = 1'b1;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset    = 1'b1;
        in_valid = 1'b0;
        chk("rst_accu0", int'(accu0), 0);
        chk("rst_flags0", int'(flags0), 0);
        chk("rst_valid0", int'(out_valid0), 0);
        chk("rst_data0", int'(out_data0), 0);
        chk("rst_in_ready0", int'(in_ready0), 1);
        chk("rst_accu1", int'(accu1), 0);
        chk("rst_in_ready1", int'(in_ready1), 1);
        @(posedge clk); #1;
        chk("rst_beats_valid", int'(out_valid0), 0);

        do_op(5, 0, 1'b1, 0, 1'b0, 1'b0);
        chk("load_out", last_out0, 5);
        chk("load_accu", last_acc0, 5);
        chk("load_flags", last_fl0, 0);

        do_op(12, 0, 1'b1, 0, 1'b0, 1'b0);
        do_op(7, 3, 1'b0, 1, 1'b0, 1'b0);
        chk("add_out", last_out0, 3);
        chk("add_flags", last_fl0, 2);
        chk("add_sat_out", last_out1, 15);
        chk("add_sat_carry", (last_fl1 >> 1) & 1, 1);

        do_op(5, 0, 1'b1, 0, 1'b0, 1'b0);
        do_op(5, 1, 1'b0, 0, 1'b0, 1'b0);
        chk("sub_eq_out", last_out0, 0);
        chk("sub_eq_flags", last_fl0, 1);

        do_op(3, 1, 1'b0, 0, 1'b0, 1'b0);
        chk("sub_borrow_out", last_out0, 14);
        chk("sub_borrow_flags", last_fl0, 10);
        chk("sub_sat_out", last_out1, 0);

        do_op(7, 0, 1'b1, 0, 1'b0, 1'b0);
        do_op(8, 1, 1'b0, 0, 1'b0, 1'b0);
        chk("sub_ovf_flags", last_fl0, 4);

        do_op(2, 0, 1'b1, 4, 1'b1, 1'b0);
        chk("bp_accu", int'(accu0), 2);

        do_op(9, 0, 1'b1, 0, 1'b0, 1'b0);
        do_op(3, 3, 1'b1, 0, 1'b0, 1'b1);
        chk("midrst_accu0", int'(accu0), 0);
        chk("midrst_accu1", int'(accu1), 0);
        chk("midrst_valid", int'(out_valid0), 0);
        chk("midrst_flags", int'(flags0), 0);
        chk("midrst_in_ready", int'(in_ready0), 1);
        do_op(4, 3, 1'b1, 0, 1'b0, 1'b0);
        chk("after_rst_add", last_out0, 4);

        for (int n = 0; n < 150; n++) begin
            if ($urandom_range(0, 3) == 0) begin
                out_ready = 1'b1;
                @(posedge clk); #1;
                out_ready = 1'b0;
            end
            do_op(int'($urandom_range(0, M - 1)), int'($urandom_range(0, 7)),
                  1'($urandom_range(0, 1)), int'($urandom_range(0, 3)), 1'b0, 1'b0);
        end

        repeat (3) @(posedge clk);
        #1;
        chk("scoreboard_empty", sb_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
